load_store_unit: RTL and testbench

MEM-stage load/store unit of the RV32I five-stage pipeline. Takes the memory-access fields of the instruction currently in MEM (address from ALUResultM, store data, funct3, read/write enables) and runs a req/ready transaction on the data-memory bus. It produces the aligned, extended ReadDataM that the MEM/WB register captures, and raises StallM so the hazard unit freezes upstream stages and bubbles RegWriteM into MEM/WB while an access is outstanding.

---
 rtl/rv32i_pkg.sv | 19 +
 rtl/lsu_load_align.sv | 35 +++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the MEM-stage load/store unit:
// funct3 access-width codes, LSU state encoding and default bus timeout.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of the captured bus word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: checks alignment, runs one req/ready data-bus transfer
// per memory instruction (IDLE -> WAIT -> RESP) and stalls the pipeline meanwhile.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic        we_q, berr_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [15:0] cnt_q, cnt_d;

  logic        access, fault, accept, timeout;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_data;

  assign access = MemReadM | MemWriteM;

  always_comb begin
    case (Funct3M)
      F3_B, F3_BU: fault = 1'b0;
      F3_H, F3_HU: fault = ALUResultM[0];
      F3_W:        fault = |ALUResultM[1:0];
      default:     fault = 1'b1;
    endcase
  end

  // Width comes from funct3[1:0]; unsigned loads share the signed encodings there.
  always_comb begin
    case (Funct3M[1:0])
      2'b00: begin
        be_new    = 4'b0001 << ALUResultM[1:0];
        wdata_new = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {ALUResultM[1], 1'b0};
        wdata_new = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = WriteDataM;
      end
    endcase
  end

  assign accept  = (state_q == LSU_IDLE) && access && !fault;
  assign cnt_d   = cnt_q + 16'd1;
  assign timeout = !dmem_ready && (cnt_d == TMO);

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept) state_d = LSU_WAIT;
      LSU_WAIT: if (dmem_ready || timeout) state_d = LSU_RESP;
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      berr_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= MemWriteM;
        addr_q  <= {ALUResultM[31:2], 2'b00};
        be_q    <= be_new;
        wdata_q <= wdata_new;
        f3_q    <= Funct3M;
        off_q   <= ALUResultM[1:0];
        cnt_q   <= '0;
        berr_q  <= 1'b0;
      end
      if (state_q == LSU_WAIT) begin
        if (dmem_ready) begin
          if (!we_q) rdata_q <= dmem_rdata;
        end else begin
          cnt_q <= cnt_d;
          if (timeout) berr_q <= 1'b1;
        end
      end
    end
  end

  lsu_load_align u_load_align (
    .word_i   (rdata_q),
    .funct3_i (f3_q),
    .offset_i (off_q),
    .data_o   (load_data)
  );

  assign dmem_req   = (state_q == LSU_WAIT);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

  // rst_n gates the combinational IDLE decisions so nothing upstream freezes in reset.
  assign StallM    = rst_n && ((state_q == LSU_WAIT) || accept);
  assign MisalignM = rst_n && (state_q == LSU_IDLE) && access && fault;
  assign BusErrM   = (state_q == LSU_RESP) && berr_q;
  assign ReadDataM = ((state_q == LSU_RESP) && !we_q && !berr_q) ? load_data : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by random
// transactions, checked against a behavioural model of the access rules.
module tb_load_store_unit;
  import rv32i_pkg::*;

  localparam int TMO = 4;

  logic        clk, rst_n;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, BusErrM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;

  int errors = 0;
  int checks = 0;
  int txn_no = 0;

  int          last_stalls, last_reqs;
  logic [31:0] last_rd, last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we, last_berr, last_mis;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access rules written as plain arithmetic ----
  function automatic int m_bytes(input logic [2:0] f3);
    int w;
    w = int'(f3) % 4;
    return (w == 0) ? 1 : (w == 1) ? 2 : 4;
  endfunction

  function automatic logic m_fault(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    return (a % m_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] mask;
    n = m_bytes(f3);
    mask = (32'd1 << n) - 1;
    if (n != 4) mask = mask << (a % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (m_bytes(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] w, input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // One instruction through MEM. rdly: number of WAIT cycles without ready before
  // ready is driven (-1 = ready never comes).
  task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] word, input int rdly);
    logic acc, st, flt, tmo;
    int nwait;
    logic [31:0] exp_rd;
    acc = rd | wr;
    st  = wr;
    flt = acc && m_fault(f3, a);
    tmo = !(rdly >= 0 && rdly < TMO);
    nwait = tmo ? TMO : rdly + 1;
    last_stalls = 0; last_reqs = 0; last_berr = 0; last_rd = 0;
    last_addr = 0; last_be = 0; last_wdata = 0; last_we = 0;

    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
    dmem_ready = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    @(negedge clk);
    last_mis = MisalignM;
    if (StallM === 1'b1) last_stalls++;
    check("idle_misalign", MisalignM, flt);
    check("idle_stall", StallM, acc && !flt);
    check("idle_quiet", {dmem_req, BusErrM, ReadDataM}, 34'd0);
    @(posedge clk); #1;

    if (acc && !flt) begin
      for (int w = 1; w <= nwait; w++) begin
        dmem_ready = (w == rdly + 1);
        dmem_rdata = dmem_ready ? word : $urandom;
        @(negedge clk);
        if (StallM === 1'b1) last_stalls++;
        if (dmem_req === 1'b1) last_reqs++;
        last_addr = dmem_addr; last_be = dmem_be; last_wdata = dmem_wdata; last_we = dmem_we;
        check("wait_bus", {dmem_req, StallM, dmem_we, dmem_addr, dmem_be, dmem_wdata},
              {1'b1, 1'b1, st, a & 32'hFFFF_FFFC, m_be(f3, a), m_wdata(f3, wd)});
        check("wait_flags", {MisalignM, BusErrM, ReadDataM}, 34'd0);
        @(posedge clk); #1;
      end
      dmem_ready = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      @(negedge clk);
      exp_rd = (tmo || st) ? 32'd0 : m_load(f3, word, a);
      last_rd = ReadDataM; last_berr = BusErrM;
      check("resp_rdata", ReadDataM, exp_rd);
      check("resp_buserr", BusErrM, tmo);
      check("resp_quiet", {StallM, dmem_req, MisalignM}, 3'd0);
      @(posedge clk); #1;
    end
    MemReadM = 0; MemWriteM = 0; dmem_ready = 0;
    txn_no++;
    $display("txn %0d rd=%b wr=%b f3=%0d a=%h wd=%h word=%h rdly=%0d stalls=%0d rd_out=%h",
             txn_no, rd, wr, f3, a, wd, word, rdly, last_stalls, last_rd);
  endtask

  initial begin
    logic [2:0]  lf3 [5];
    logic [31:0] ra, rw, rword;
    logic [2:0]  rf3;
    int kind, rdl;
    lf3[0] = F3_B; lf3[1] = F3_H; lf3[2] = F3_W; lf3[3] = F3_BU; lf3[4] = F3_HU;

    rst_n = 0; MemReadM = 0; MemWriteM = 0; Funct3M = 0; ALUResultM = 0;
    WriteDataM = 0; dmem_rdata = 0; dmem_ready = 0;
    #1;
    check("rst_bus", {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be}, 70'd0);
    check("rst_flags", {ReadDataM, StallM, MisalignM, BusErrM}, 35'd0);
    MemReadM = 1; Funct3M = F3_W; ALUResultM = 32'h100;
    #1;
    check("rst_stall_forced_low", StallM, 1'b0);
    @(negedge clk); #2;
    rst_n = 1; MemReadM = 0;
    @(posedge clk); #1;

    txn(1, 0, F3_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    check("lw_stall_cycles", last_stalls, 2);
    check("lw_be", last_be, 4'b1111);
    check("lw_rdata", last_rd, 32'hDEAD_BEEF);

    txn(1, 0, F3_B, 32'h103, 32'h0, 32'h80FF_0000, 0);
    check("lb_rdata", last_rd, 32'hFFFF_FF80);
    txn(1, 0, F3_BU, 32'h103, 32'h0, 32'h80FF_0000, 0);
    check("lbu_rdata", last_rd, 32'h0000_0080);

    txn(0, 1, F3_H, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 0);
    check("sh_bus", {last_addr, last_be, last_wdata, last_we}, {32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1});
    check("sh_rdata", last_rd, 32'd0);

    txn(1, 0, F3_W, 32'h101, 32'h0, 32'h0, 0);
    check("lw_misalign", {last_mis, last_stalls}, {1'b1, 32'd0});
    txn(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    check("f3_011_fault", {last_mis, last_stalls}, {1'b1, 32'd0});

    txn(1, 0, F3_W, 32'h400, 32'h0, 32'h1111_2222, -1);
    check("timeout_reqs", last_reqs, TMO);
    check("timeout_buserr", {last_berr, last_rd}, {1'b1, 32'd0});
    txn(1, 0, F3_W, 32'h404, 32'h0, 32'h3333_4444, TMO - 1);
    check("ready_at_limit", {last_berr, last_rd, last_stalls}, {1'b0, 32'h3333_4444, 32'(TMO + 1)});

    txn(0, 0, F3_W, 32'h500, 32'h0, 32'h0, 0);
    check("nonmem_pass", last_stalls, 0);
    txn(1, 1, F3_W, 32'h504, 32'hCAFE_F00D, 32'h7777_8888, 1);
    check("rd_wr_is_store", {last_we, last_rd}, {1'b1, 32'd0});

    // Reset pulse while the request is outstanding.
    MemReadM = 1; Funct3M = F3_W; ALUResultM = 32'h300;
    @(posedge clk); #1;
    dmem_ready = 0;
    @(negedge clk);
    check("mid_wait_req", {dmem_req, StallM}, 2'b11);
    #2 rst_n = 0;
    #1;
    check("async_reset_drop", {dmem_req, StallM}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check("held_reset_quiet", {dmem_req, StallM, ReadDataM}, 34'd0);
    #2 rst_n = 1; MemReadM = 0;
    @(posedge clk); #1;
    txn(1, 0, F3_W, 32'h310, 32'h0, 32'h0BAD_F00D, 0);
    check("post_reset_lw", {last_stalls, last_rd}, {32'd2, 32'h0BAD_F00D});

    for (int i = 0; i < 80; i++) begin
      kind  = int'($urandom_range(0, 9));
      ra    = $urandom;
      if ($urandom_range(0, 2) != 0) ra = ra & 32'hFFFF_FFFC;
      rw    = $urandom;
      rword = $urandom;
      rdl   = int'($urandom_range(0, 6)) - 1;
      if (kind == 0) begin
        txn(0, 0, 3'($urandom_range(0, 7)), ra, rw, rword, rdl);
      end else if (kind <= 5) begin
        rf3 = lf3[$urandom_range(0, 4)];
        txn(1, 0, rf3, ra, rw, rword, rdl);
      end else if (kind <= 8) begin
        rf3 = 3'($urandom_range(0, 2));
        txn(0, 1, rf3, ra, rw, rword, rdl);
      end else begin
        rf3 = ($urandom_range(0, 1) != 0) ? 3'b110 : 3'b111;
        txn(1, 0, rf3, ra, rw, rword, rdl);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
